// File: rtl/sort_scheduler.sv
// sort_scheduler
// ----------------------------------------------------------------------------
// Sequencer in front of the chip sorter. Colour classifications from the
// colour-sense stage are buffered in a small FIFO and arbitrated against lift
// requests. One job at a time is issued to the sorter over its
// colour/start/complete interface; the idle code (3'b111) is driven between
// jobs so that two identical colours in a row are re-latched by the sorter.
// A job that never completes within TIMEOUT cycles raises a fault.
//
// Handshakes:
//   Chip input is valid/ready: a code is taken on a rising clk edge when
//   chip_valid && chip_ready. Codes 101/110/111 are dropped silently.
//   Sorter side: sort_colour is held for the whole job; sort_complete is a
//   level that stays high until sort_colour changes. A stale high level left
//   from the previous job is ignored until it has dropped.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   chip_valid      classified chip available
//   chip_colour[2:0] 000 red, 001 green, 010 blue, 011 bin, 100 recycle
//   chip_ready      FIFO not full
//   lift_req        lift request (pulse or level)
//   sort_complete   sorter done flag
//   sort_start      sorter enable (low only while faulted or in reset)
//   sort_colour[2:0] job code to sorter; 101 lift, 111 idle
//   busy            state is not IDLE
//   queue_count     FIFO occupancy
//   fault           job timeout fault
//   fault_clear     leave FAULT
//   sorted_count    completed chip jobs (wraps at 16 bits)
// ----------------------------------------------------------------------------
module sort_scheduler #(
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 250000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chip_valid,
    input  logic [2:0]       chip_colour,
    output logic             chip_ready,
    input  logic             lift_req,
    input  logic             sort_complete,
    output logic             sort_start,
    output logic [2:0]       sort_colour,
    output logic             busy,
    output logic [CNT_W-1:0] queue_count,
    output logic             fault,
    input  logic             fault_clear,
    output logic [15:0]      sorted_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [2:0] CODE_LIFT = 3'b101;
    localparam logic [2:0] CODE_IDLE = 3'b111;
    localparam logic [2:0] CODE_MAX  = 3'b100;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              lift_pending_q, lift_pending_d;
    logic [2:0]        sort_colour_q, sort_colour_d;
    logic              sort_start_q, sort_start_d;
    logic              fault_q, fault_d;
    logic              busy_q, busy_d;
    logic [15:0]       sorted_count_q, sorted_count_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              fifo_ready;
    logic              push;
    logic              pop;
    logic              take_lift;
    logic [2:0]        fifo_head;

    // Ready depends only on registered occupancy, so a full FIFO that pops
    // this cycle still refuses a push until the next one.
    assign fifo_ready = (count_q != CNT_FULL);
    assign push       = chip_valid && fifo_ready && (chip_colour <= CODE_MAX);
    assign fifo_head  = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        sort_colour_d  = sort_colour_q;
        sorted_count_d = sorted_count_q;
        tmo_d          = '0;
        gap_d          = '0;
        pop            = 1'b0;
        take_lift      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (lift_pending_q) begin
                    sort_colour_d = CODE_LIFT;
                    take_lift     = 1'b1;
                    state_d       = S_ISSUE;
                end else if (count_q != '0) begin
                    sort_colour_d = fifo_head;
                    pop           = 1'b1;
                    state_d       = S_ISSUE;
                end else begin
                    sort_colour_d = CODE_IDLE;
                end
            end

            S_ISSUE: begin
                // Leave only once the previous job's complete flag has
                // dropped, otherwise WAIT would see it as this job's.
                if (tmo_q == TMO_LAST) begin
                    sort_colour_d = CODE_IDLE;
                    state_d       = S_FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (!sort_complete) begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                // Completion is checked first so it beats a same-cycle timeout.
                if (sort_complete) begin
                    sort_colour_d = CODE_IDLE;
                    state_d       = S_GAP;
                    if (sort_colour_q != CODE_LIFT) begin
                        sorted_count_d = sorted_count_q + 16'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    sort_colour_d = CODE_IDLE;
                    state_d       = S_FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_GAP: begin
                sort_colour_d = CODE_IDLE;
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            S_FAULT: begin
                // The timed-out job is simply dropped here.
                sort_colour_d = CODE_IDLE;
                if (fault_clear) begin
                    state_d = S_GAP;
                end
            end

            default: begin
                sort_colour_d = CODE_IDLE;
                state_d       = S_IDLE;
            end
        endcase

        // A request arriving while a lift is being dispatched or running
        // re-arms the flag, so exactly one further lift follows.
        lift_pending_d = lift_pending_q;
        if (take_lift) begin
            lift_pending_d = 1'b0;
        end
        if (lift_req) begin
            lift_pending_d = 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        sort_start_d = (state_d != S_FAULT);
        fault_d      = (state_d == S_FAULT);
        busy_d       = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            lift_pending_q <= 1'b0;
            sort_colour_q  <= CODE_IDLE;
            sort_start_q   <= 1'b0;
            fault_q        <= 1'b0;
            busy_q         <= 1'b0;
            sorted_count_q <= '0;
            tmo_q          <= '0;
            gap_q          <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            lift_pending_q <= lift_pending_d;
            sort_colour_q  <= sort_colour_d;
            sort_start_q   <= sort_start_d;
            fault_q        <= fault_d;
            busy_q         <= busy_d;
            sorted_count_q <= sorted_count_d;
            tmo_q          <= tmo_d;
            gap_q          <= gap_d;
        end
    end

    // Storage needs no reset: entries are only read below the occupancy count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= chip_colour;
        end
    end

    assign chip_ready   = fifo_ready;
    assign sort_start   = sort_start_q;
    assign sort_colour  = sort_colour_q;
    assign busy         = busy_q;
    assign queue_count  = count_q;
    assign fault        = fault_q;
    assign sorted_count = sorted_count_q;

endmodule

// File: tb/tb_sort_scheduler.sv
// Testbench for sort_scheduler: a behavioural sorter model answers each job
// after a programmable delay, a monitor compares every dispatched job code
// against an expected queue, and directed sequences cover the corner cases.
module tb_sort_scheduler;

    localparam int DEPTH      = 8;
    localparam int CNT_W      = 4;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             chip_valid = 1'b0;
    logic [2:0]       chip_colour = 3'b000;
    logic             chip_ready;
    logic             lift_req = 1'b0;
    logic             sort_complete = 1'b0;
    logic             sort_start;
    logic [2:0]       sort_colour;
    logic             busy;
    logic [CNT_W-1:0] queue_count;
    logic             fault;
    logic             fault_clear = 1'b0;
    logic [15:0]      sorted_count;

    sort_scheduler #(
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chip_valid    (chip_valid),
        .chip_colour   (chip_colour),
        .chip_ready    (chip_ready),
        .lift_req      (lift_req),
        .sort_complete (sort_complete),
        .sort_start    (sort_start),
        .sort_colour   (sort_colour),
        .busy          (busy),
        .queue_count   (queue_count),
        .fault         (fault),
        .fault_clear   (fault_clear),
        .sorted_count  (sorted_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    int         dispatches = 0;
    int         gap_run = 0;
    int         last_gap = 0;
    int         sorter_delay = -1;   // -1: sorter never completes
    logic [2:0] prev_col = 3'b111;
    logic [2:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- sorter model ----------------
    // complete drops whenever the colour changes and rises sorter_delay
    // cycles after a non-idle colour appears.
    initial begin : sorter_model
        logic [2:0] last_col;
        int         cnt;
        last_col = 3'b111;
        cnt      = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                sort_complete = 1'b0;
                last_col      = 3'b111;
                cnt           = 0;
            end else if (sort_colour != last_col) begin
                last_col      = sort_colour;
                sort_complete = 1'b0;
                cnt           = 0;
            end else if (sort_colour != 3'b111 && sorter_delay >= 0 && !sort_complete) begin
                cnt++;
                if (cnt >= sorter_delay) sort_complete = 1'b1;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_col = 3'b111;
            gap_run  = 0;
        end else begin
            if (sort_colour == 3'b111) begin
                gap_run++;
            end else if (prev_col == 3'b111) begin
                last_gap = gap_run;
                gap_run  = 0;
                dispatches++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dispatch: got %0b expected no job", sort_colour);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("dispatch", sort_colour, mon_exp);
                end
            end
            prev_col = sort_colour;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_chip(input logic [2:0] c);
        chip_valid  = 1'b1;
        chip_colour = c;
        if (c <= 3'b100) exp_q.push_back(c);
        tick(1);
        chip_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        chip_valid  = 1'b0;
        lift_req    = 1'b0;
        fault_clear = 1'b0;
        tick(2);
        exp_q.delete();
        check("rst_start", sort_start, 0);
        check("rst_colour", sort_colour, 3'b111);
        check("rst_count", queue_count, 0);
        check("rst_ready", chip_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_sorted", sorted_count, 0);
        rst = 1'b0;
        tick(1);
        check("rst_start_after", sort_start, 1);
    endtask

    task automatic wait_sorted(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (sorted_count != 16'(target) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, sorted_count, 16'(target));
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (!(sorted_count == 16'(target) && !busy) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, (n < budget), 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             valid;
        logic [2:0]       colour;
        logic             exp_ready;
        logic [CNT_W-1:0] exp_count;
    } vec_t;

    vec_t tbl [15];
    int   d0;

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // Stalled sorter; the first accepted chip is popped into a job on the
        // next edge, so nine accepted pushes fill the eight entries.
        tbl[0]  = '{1'b1, 3'b000, 1'b1, 4'd1};
        tbl[1]  = '{1'b1, 3'b001, 1'b1, 4'd1};
        tbl[2]  = '{1'b1, 3'b110, 1'b1, 4'd1};
        tbl[3]  = '{1'b1, 3'b010, 1'b1, 4'd2};
        tbl[4]  = '{1'b0, 3'b011, 1'b1, 4'd2};
        tbl[5]  = '{1'b1, 3'b011, 1'b1, 4'd3};
        tbl[6]  = '{1'b1, 3'b100, 1'b1, 4'd4};
        tbl[7]  = '{1'b1, 3'b111, 1'b1, 4'd4};
        tbl[8]  = '{1'b1, 3'b000, 1'b1, 4'd5};
        tbl[9]  = '{1'b1, 3'b001, 1'b1, 4'd6};
        tbl[10] = '{1'b1, 3'b010, 1'b1, 4'd7};
        tbl[11] = '{1'b1, 3'b101, 1'b1, 4'd7};
        tbl[12] = '{1'b1, 3'b011, 1'b1, 4'd8};
        tbl[13] = '{1'b1, 3'b100, 1'b0, 4'd8};
        tbl[14] = '{1'b1, 3'b000, 1'b0, 4'd8};

        do_reset();

        // Single chip
        sorter_delay = 3;
        push_chip(3'b000);
        check("t1_count_push", queue_count, 1);
        check("t1_idle_colour", sort_colour, 3'b111);
        check("t1_idle_busy", busy, 0);
        tick(1);
        check("t1_dispatch_colour", sort_colour, 3'b000);
        check("t1_dispatch_busy", busy, 1);
        check("t1_dispatch_count", queue_count, 0);
        wait_sorted("t1_sorted", 1, 20);
        check("t1_gap_colour", sort_colour, 3'b111);
        check("t1_gap_busy", busy, 1);
        tick(GAP_CYCLES - 1);
        check("t1_gap_hold_busy", busy, 1);
        check("t1_gap_hold_colour", sort_colour, 3'b111);
        tick(1);
        check("t1_idle_after_gap", busy, 0);

        // Back-to-back identical colours
        sorter_delay = 2;
        push_chip(3'b001);
        push_chip(3'b001);
        wait_done("t2_done", 3, 80);
        check("t2_sorted", sorted_count, 3);
        check("t2_queue_drained", exp_q.size(), 0);
        // Idle code spans the GAP state plus the IDLE cycle before dispatch.
        check("t2_gap_len", (last_gap >= GAP_CYCLES && last_gap <= GAP_CYCLES + 1), 1);

        // Back-pressure and dropped codes
        do_reset();
        sorter_delay = -1;
        for (int i = 0; i < 15; i++) begin
            check("t3_ready", chip_ready, tbl[i].exp_ready);
            chip_valid  = tbl[i].valid;
            chip_colour = tbl[i].colour;
            if (tbl[i].valid && tbl[i].colour <= 3'b100 && tbl[i].exp_ready)
                exp_q.push_back(tbl[i].colour);
            tick(1);
            chip_valid = 1'b0;
            check("t3_count", queue_count, tbl[i].exp_count);
        end
        check("t3_ready_full", chip_ready, 0);

        // Lift priority, merged requests
        do_reset();
        sorter_delay = 3;
        d0 = dispatches;
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b011);
        chip_valid  = 1'b1;
        chip_colour = 3'b010;
        tick(1);
        chip_colour = 3'b011;
        tick(1);
        chip_valid = 1'b0;
        lift_req   = 1'b1;
        tick(2);
        lift_req = 1'b0;
        wait_done("t4_done", 2, 150);
        check("t4_sorted", sorted_count, 2);
        check("t4_queue_drained", exp_q.size(), 0);
        tick(20);
        check("t4_dispatches", dispatches - d0, 3);

        // Timeout, FIFO kept open in FAULT, recovery
        do_reset();
        sorter_delay = -1;
        push_chip(3'b100);
        push_chip(3'b011);
        check("t5_dispatch", sort_colour, 3'b100);
        tick(TIMEOUT - 1);
        check("t5_no_fault_yet", fault, 0);
        check("t5_start_before", sort_start, 1);
        tick(1);
        check("t5_fault", fault, 1);
        check("t5_start_frozen", sort_start, 0);
        check("t5_fault_colour", sort_colour, 3'b111);
        push_chip(3'b001);
        check("t5_fifo_in_fault", queue_count, 2);
        check("t5_fault_held", fault, 1);
        sorter_delay = 2;
        fault_clear  = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        check("t5_clear_fault", fault, 0);
        check("t5_clear_start", sort_start, 1);
        check("t5_clear_gap_busy", busy, 1);
        check("t5_clear_colour", sort_colour, 3'b111);
        wait_done("t5_recover", 2, 150);
        check("t5_sorted", sorted_count, 2);
        check("t5_queue_drained", exp_q.size(), 0);

        // Completion arrives on the very cycle the timeout would fire
        sorter_delay = TIMEOUT - 1;
        push_chip(3'b010);
        tick(1);
        wait_sorted("t6_complete_wins", 3, TIMEOUT + 10);
        check("t6_no_fault", fault, 0);
        wait_done("t6_done", 3, 40);

        // Reset in the middle of a WAIT with three chips queued
        sorter_delay = -1;
        push_chip(3'b000);
        push_chip(3'b001);
        push_chip(3'b010);
        push_chip(3'b011);
        tick(3);
        check("t7_queued", queue_count, 3);
        check("t7_busy", busy, 1);
        rst = 1'b1;
        tick(1);
        check("t7_rst_count", queue_count, 0);
        check("t7_rst_colour", sort_colour, 3'b111);
        check("t7_rst_start", sort_start, 0);
        check("t7_rst_sorted", sorted_count, 0);
        check("t7_rst_fault", fault, 0);
        check("t7_rst_busy", busy, 0);
        exp_q.delete();
        rst = 1'b0;
        tick(1);
        check("t7_start_after", sort_start, 1);
        sorter_delay = 2;
        push_chip(3'b100);
        wait_done("t7_after_reset", 1, 40);
        check("t7_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
